// File: rtl/arduino_link.sv
// arduino_link: processor-word <-> Arduino byte link over four-phase strobes.
// RX assembles bytes LSB-first into a word; TX drains a word FIFO bytewise.
module arduino_link #(
  parameter int BYTE_LENGTH = 8,
  parameter int DATA_LENGTH = 32,
  parameter int TX_DEPTH    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flag_write_arduino,
  input  logic [DATA_LENGTH-1:0] module_input,
  input  logic                   flag_read_arduino,
  output logic [DATA_LENGTH-1:0] module_output,
  output logic                   rx_valid,
  output logic                   tx_full,
  output logic                   tx_busy,
  output logic [1:0]             error_flags,
  input  logic [BYTE_LENGTH-1:0] system_input,
  input  logic                   system_input_strobe,
  output logic [BYTE_LENGTH-1:0] system_output,
  output logic                   system_output_strobe,
  input  logic                   system_output_ack
);

  localparam int NBYTES = DATA_LENGTH / BYTE_LENGTH;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef logic [NBYTES-1:0][BYTE_LENGTH-1:0] word_t;

  // Gray-coded so every legal transition flips one bit and the
  // decoded strobe cannot glitch toward the Arduino.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LOAD     = 2'b01,
    REQ      = 2'b11,
    WAIT_LOW = 2'b10
  } state_e;

  logic stb_s1_q, stb_s2_q, stb_prev_q;
  logic ack_s1_q, ack_s2_q;
  logic rx_edge;

  word_t          rx_buf_q, rx_buf_d, rx_asm;
  word_t          rx_out_q, rx_out_d;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic           rx_valid_q, rx_valid_d;
  logic [1:0]     err_q, err_d;
  logic           rd_ok, word_done, overrun;

  logic [DATA_LENGTH-1:0] mem_q [TX_DEPTH];
  logic [PW:0]    wr_q, rd_q;
  logic           empty, full, push_ok, pop;

  state_e         state_q, state_d;
  word_t          sh_q;
  logic [CW-1:0]  idx_q;

  // Two-flop synchronizers plus edge-detect history for the RX strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      stb_s1_q   <= 1'b0;
      stb_s2_q   <= 1'b0;
      stb_prev_q <= 1'b0;
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
    end else begin
      stb_s1_q   <= system_input_strobe;
      stb_s2_q   <= stb_s1_q;
      stb_prev_q <= stb_s2_q;
      ack_s1_q   <= system_output_ack;
      ack_s2_q   <= ack_s1_q;
    end
  end

  assign rx_edge   = stb_s2_q & ~stb_prev_q;
  assign word_done = rx_edge && (rx_cnt_q == LAST);
  assign rd_ok     = flag_read_arduino & rx_valid_q;
  assign overrun   = word_done & rx_valid_q & ~rd_ok;
  assign push_ok   = flag_write_arduino & ~full;
  assign pop       = (state_q == LOAD);

  // RX assembly, hand-off to the processor and sticky error flags
  always_comb begin
    rx_asm           = rx_buf_q;
    rx_asm[rx_cnt_q] = system_input;
    rx_buf_d         = rx_edge ? rx_asm : rx_buf_q;
    rx_cnt_d         = rx_cnt_q;
    if (rx_edge) begin
      rx_cnt_d = (rx_cnt_q == LAST) ? '0 : rx_cnt_q + 1'b1;
    end
    rx_valid_d = rx_valid_q;
    rx_out_d   = rx_out_q;
    if (rd_ok) begin
      rx_valid_d = 1'b0;
    end
    if (word_done && (!rx_valid_q || rd_ok)) begin
      rx_valid_d = 1'b1;
      rx_out_d   = rx_asm;
    end
    err_d = err_q;
    if (flag_read_arduino) err_d[0] = 1'b0;
    if (overrun)           err_d[0] = 1'b1;
    if (push_ok)           err_d[1] = 1'b0;
    if (flag_write_arduino && full) err_d[1] = 1'b1;
  end

  // RX and error state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_buf_q   <= '0;
      rx_out_q   <= '0;
      rx_cnt_q   <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      rx_buf_q   <= rx_buf_d;
      rx_out_q   <= rx_out_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);

  // FIFO pointers; full is judged before this cycle's pop
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  // FIFO storage needs no reset; the pointers define its contents
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q[PW-1:0]] <= module_input;
  end

  // TX FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // TX FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (!empty) state_d = LOAD;
      LOAD:     state_d = REQ;
      REQ:      if (ack_s2_q) state_d = WAIT_LOW;
      WAIT_LOW: if (!ack_s2_q) state_d = (idx_q != LAST) ? REQ : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // TX shift register and byte index
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (state_q == LOAD) begin
      sh_q  <= mem_q[rd_q[PW-1:0]];
      idx_q <= '0;
    end else if (state_q == WAIT_LOW && !ack_s2_q && idx_q != LAST) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // TX outputs decoded from registered state only
  always_comb begin
    system_output_strobe = (state_q == REQ);
    system_output        = sh_q[idx_q];
    tx_busy              = (state_q != IDLE) || !empty;
  end

  assign module_output = rx_out_q;
  assign rx_valid      = rx_valid_q;
  assign tx_full       = full;
  assign error_flags   = err_q;

endmodule
